// File: rtl/logic_unit_pipe.sv
// logic_unit_pipe: applies one of eight bitwise logic functions to two
// WIDTH-bit operands and presents the result, zero and parity flags and the
// producing opcode from a single pipeline register with valid/ready on both
// sides. A saturating counter tracks completed output transfers.
module logic_unit_pipe #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [2:0]       in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_y,
  output logic             out_zero,
  output logic             out_parity,
  output logic [2:0]       out_op,
  output logic [CNT_W-1:0] txn_count
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1'b1);

  // Bitwise function selected by the opcode; every code is legal.
  function automatic logic [WIDTH-1:0] logic_fn(
    input logic [WIDTH-1:0] a,
    input logic [WIDTH-1:0] b,
    input logic [2:0]       op
  );
    logic [WIDTH-1:0] r;
    case (op)
      3'd0:    r = a & b;
      3'd1:    r = a | b;
      3'd2:    r = ~a;
      3'd3:    r = ~(a & b);
      3'd4:    r = ~(a | b);
      3'd5:    r = a ^ b;
      3'd6:    r = ~(a ^ b);
      3'd7:    r = b;
      default: r = {WIDTH{1'b0}};
    endcase
    return r;
  endfunction

  // Even parity of a result word (1 when an odd number of bits are set).
  function automatic logic parity_of(input logic [WIDTH-1:0] v);
    return ^v;
  endfunction

  logic             valid_q,  valid_d;
  logic [WIDTH-1:0] y_q,      y_d;
  logic             zero_q,   zero_d;
  logic             parity_q, parity_d;
  logic [2:0]       op_q,     op_d;
  logic [CNT_W-1:0] cnt_q,    cnt_d;

  logic             accept_s;
  logic             xfer_s;
  logic [WIDTH-1:0] result_s;

  // The stage can take a new operand set whenever it is empty or being drained.
  assign in_ready   = !valid_q || out_ready;
  assign accept_s   = in_valid && in_ready;
  assign xfer_s     = valid_q && out_ready;
  assign result_s   = logic_fn(in_a, in_b, in_op);

  assign out_valid  = valid_q;
  assign out_y      = y_q;
  assign out_zero   = zero_q;
  assign out_parity = parity_q;
  assign out_op     = op_q;
  assign txn_count  = cnt_q;

  // Next-state for the result register: load on accept, empty on a lone transfer.
  always_comb begin
    valid_d  = valid_q;
    y_d      = y_q;
    zero_d   = zero_q;
    parity_d = parity_q;
    op_d     = op_q;
    if (accept_s) begin
      valid_d  = 1'b1;
      y_d      = result_s;
      zero_d   = (result_s == {WIDTH{1'b0}});
      parity_d = parity_of(result_s);
      op_d     = in_op;
    end else if (xfer_s) begin
      valid_d  = 1'b0;
    end else begin
      valid_d  = valid_q;
    end
  end

  // Next-state for the transfer counter: count each delivery, stick at the top.
  always_comb begin
    cnt_d = cnt_q;
    if (xfer_s && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_ONE;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // State registers; reset discards any held result and clears the counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q  <= 1'b0;
      y_q      <= {WIDTH{1'b0}};
      zero_q   <= 1'b1;
      parity_q <= 1'b0;
      op_q     <= 3'd0;
      cnt_q    <= {CNT_W{1'b0}};
    end else begin
      valid_q  <= valid_d;
      y_q      <= y_d;
      zero_q   <= zero_d;
      parity_q <= parity_d;
      op_q     <= op_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Testbench for logic_unit_pipe: three instances (8-bit, 8-bit with a 3-bit
// counter, 1-bit) share one handshake stream; a scoreboard queue holds the
// expected results of every accepted transaction until it is delivered.
module tb_logic_unit_pipe;

  typedef struct packed {
    logic [7:0] y;
    logic       z;
    logic       p;
    logic [2:0] op;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [7:0]  in_a;
  logic [7:0]  in_b;
  logic [2:0]  in_op;
  logic        out_ready;

  logic        rdy8, rdys, rdy1;
  logic        val8, vals, val1;
  logic [7:0]  y8, ys;
  logic        y1;
  logic        z8, zs, z1;
  logic        p8, ps, p1;
  logic [2:0]  op8, ops, op1;
  logic [15:0] cnt8, cnt1;
  logic [2:0]  cnts;

  int checks   = 0;
  int failures = 0;

  exp_t q8[$];
  exp_t q1[$];
  int   m_cnt8;
  int   m_cnts;

  logic [7:0] sweep_tab [8];

  always #5 clk = ~clk;

  logic_unit_pipe #(.WIDTH(8), .CNT_W(16)) u8 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy8),
    .in_a(in_a), .in_b(in_b), .in_op(in_op),
    .out_valid(val8), .out_ready(out_ready), .out_y(y8),
    .out_zero(z8), .out_parity(p8), .out_op(op8), .txn_count(cnt8)
  );

  logic_unit_pipe #(.WIDTH(8), .CNT_W(3)) us (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdys),
    .in_a(in_a), .in_b(in_b), .in_op(in_op),
    .out_valid(vals), .out_ready(out_ready), .out_y(ys),
    .out_zero(zs), .out_parity(ps), .out_op(ops), .txn_count(cnts)
  );

  logic_unit_pipe #(.WIDTH(1), .CNT_W(16)) u1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy1),
    .in_a(in_a[0]), .in_b(in_b[0]), .in_op(in_op),
    .out_valid(val1), .out_ready(out_ready), .out_y(y1),
    .out_zero(z1), .out_parity(p1), .out_op(op1), .txn_count(cnt1)
  );

  // Reference: per-bit truth table indexed by {a,b}.
  function automatic logic [7:0] model_y(input logic [7:0] a, input logic [7:0] b,
                                         input logic [2:0] op);
    logic [3:0] tt;
    logic [7:0] r;
    case (op)
      3'd0:    tt = 4'b1000;
      3'd1:    tt = 4'b1110;
      3'd2:    tt = 4'b0011;
      3'd3:    tt = 4'b0111;
      3'd4:    tt = 4'b0001;
      3'd5:    tt = 4'b0110;
      3'd6:    tt = 4'b1001;
      default: tt = 4'b1010;
    endcase
    for (int i = 0; i < 8; i++) r[i] = tt[{a[i], b[i]}];
    return r;
  endfunction

  function automatic logic model_par(input logic [7:0] v);
    int ones = 0;
    for (int i = 0; i < 8; i++) if (v[i]) ones++;
    return (ones % 2) == 1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One cycle: drive at the falling edge, check before the rising edge.
  task automatic step(input logic v, input logic [7:0] a, input logic [7:0] b,
                      input logic [2:0] op, input logic ordy);
    logic exp_rdy;
    exp_t e;
    exp_t e1;
    in_valid  = v;
    in_a      = a;
    in_b      = b;
    in_op     = op;
    out_ready = ordy;
    #1;
    exp_rdy = (q8.size() == 0) || ordy;
    chk("in_ready8", {31'd0, rdy8}, {31'd0, exp_rdy});
    chk("in_ready1", {31'd0, rdy1}, {31'd0, exp_rdy});
    chk("out_valid8", {31'd0, val8}, {31'd0, q8.size() != 0});
    chk("out_valid_s", {31'd0, vals}, {31'd0, q8.size() != 0});
    chk("txn_count8", {16'd0, cnt8}, m_cnt8);
    chk("txn_count_sat", {29'd0, cnts}, m_cnts);
    if ((q8.size() != 0) && ordy) begin
      e  = q8.pop_front();
      e1 = q1.pop_front();
      chk("out_y8", {24'd0, y8}, {24'd0, e.y});
      chk("out_zero8", {31'd0, z8}, {31'd0, e.z});
      chk("out_parity8", {31'd0, p8}, {31'd0, e.p});
      chk("out_op8", {29'd0, op8}, {29'd0, e.op});
      chk("out_y_s", {24'd0, ys}, {24'd0, e.y});
      chk("out_y1", {31'd0, y1}, {31'd0, e1.y[0]});
      chk("out_zero1", {31'd0, z1}, {31'd0, e1.z});
      chk("out_parity1", {31'd0, p1}, {31'd0, e1.p});
      m_cnt8 = m_cnt8 + 1;
      m_cnts = (m_cnts == 7) ? 7 : m_cnts + 1;
    end
    if (v && exp_rdy) begin
      e.y  = model_y(a, b, op);
      e.z  = (e.y == 8'h00);
      e.p  = model_par(e.y);
      e.op = op;
      q8.push_back(e);
      e1.y  = model_y(a, b, op) & 8'h01;
      e1.z  = (e1.y == 8'h00);
      e1.p  = model_par(e1.y);
      e1.op = op;
      q1.push_back(e1);
    end
    @(negedge clk);
  endtask

  initial begin
    sweep_tab = '{8'h48, 8'hDE, 8'h35, 8'hB7, 8'h21, 8'h96, 8'h69, 8'h5C};
    m_cnt8 = 0;
    m_cnts = 0;
    rst = 1'b1; in_valid = 1'b0; in_a = 8'h00; in_b = 8'h00; in_op = 3'd0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_valid", {31'd0, val8}, 32'd0);
    chk("rst_y", {24'd0, y8}, 32'd0);
    chk("rst_zero", {31'd0, z8}, 32'd1);
    chk("rst_parity", {31'd0, p8}, 32'd0);
    chk("rst_op", {29'd0, op8}, 32'd0);
    chk("rst_cnt", {16'd0, cnt8}, 32'd0);
    chk("rst_ready", {31'd0, rdy8}, 32'd1);
    @(negedge clk);

    // Opcode sweep, back-to-back, against the fixed result table.
    for (int i = 0; i < 9; i++) begin
      if (i > 0) begin
        chk("sweep_y", {24'd0, y8}, {24'd0, sweep_tab[i-1]});
        chk("sweep_par", {31'd0, p8}, 32'd0);
        chk("sweep_zero", {31'd0, z8}, 32'd0);
      end
      if (i < 8) step(1'b1, 8'hCA, 8'h5C, 3'(i), 1'b1);
      else       step(1'b0, 8'h00, 8'h00, 3'd0, 1'b1);
    end
    chk("sweep_cnt", {16'd0, cnt8}, 32'd8);

    // Zero flag cases.
    step(1'b1, 8'hF0, 8'h0F, 3'd0, 1'b1);
    step(1'b1, 8'h00, 8'h00, 3'd6, 1'b1);
    step(1'b0, 8'h00, 8'h00, 3'd0, 1'b1);

    // Backpressure: hold one result while inputs toggle.
    step(1'b1, 8'h01, 8'h00, 3'd1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 8'(i * 37 + 5), 8'hA5, 3'(i + 2), 1'b0);
      chk("bp_hold_y", {24'd0, y8}, 32'h01);
      chk("bp_ready", {31'd0, rdy8}, 32'd0);
    end
    step(1'b1, 8'h00, 8'h33, 3'd2, 1'b1);
    chk("bp_valid_kept", {31'd0, val8}, 32'd1);
    chk("bp_new_y", {24'd0, y8}, 32'hFF);
    step(1'b0, 8'h00, 8'h00, 3'd0, 1'b1);

    // Exhaustive single-bit gates (also drives the saturating counter past 7).
    for (int op = 0; op < 8; op++)
      for (int ab = 0; ab < 4; ab++)
        step(1'b1, {7'd0, 1'(ab >> 1)}, {7'd0, 1'(ab)}, 3'(op), 1'b1);
    step(1'b0, 8'h00, 8'h00, 3'd0, 1'b1);
    chk("sat_final", {29'd0, cnts}, 32'd7);

    // Reset while a result is stalled, with accept and transfer also requested.
    step(1'b1, 8'h33, 8'h0F, 3'd5, 1'b0);
    step(1'b0, 8'h00, 8'h00, 3'd0, 1'b0);
    rst = 1'b1; in_valid = 1'b1; in_a = 8'h12; in_op = 3'd1; out_ready = 1'b1;
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    q8.delete(); q1.delete(); m_cnt8 = 0; m_cnts = 0;
    #1;
    chk("mid_rst_valid", {31'd0, val8}, 32'd0);
    chk("mid_rst_y", {24'd0, y8}, 32'd0);
    chk("mid_rst_zero", {31'd0, z8}, 32'd1);
    chk("mid_rst_cnt", {16'd0, cnt8}, 32'd0);
    chk("mid_rst_ready", {31'd0, rdy8}, 32'd1);
    @(negedge clk);
    repeat (3) step(1'b0, 8'h00, 8'h00, 3'd0, 1'b1);
    chk("mid_rst_no_delivery", {16'd0, cnt8}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/logic_unit_pipe.md
Name: logic_unit_pipe

Overview:
- Parametrised, registered successor to the team's two-input single-bit gate block.
- Applies one of eight bitwise logic functions to two WIDTH-bit operands, selected per transaction by an opcode.
- Result and status flags come out of a one-stage pipeline register with valid/ready handshaking on both sides, so the block drops into streaming datapaths.
- Keeps a saturating count of completed transactions for debug and test.

Parameters:
- WIDTH, 8, operand and result width in bits (>=1).
- CNT_W, 16, width of the transaction counter (>=1).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous reset, active-high.
- in_valid  in  1  operands and opcode are valid.
- in_ready  out  1  block accepts input this cycle.
- in_a  in  WIDTH  operand A.
- in_b  in  WIDTH  operand B.
- in_op  in  3  function select (see Behaviour).
- out_valid  out  1  result register holds a valid result.
- out_ready  in  1  downstream accepts the result.
- out_y  out  WIDTH  registered result.
- out_zero  out  1  registered flag, 1 when out_y == 0.
- out_parity  out  1  registered XOR-reduction of out_y.
- out_op  out  3  registered opcode that produced out_y.
- txn_count  out  CNT_W  completed output transactions, saturating.

Behaviour:
- One clock domain, clk. Reset is synchronous and active-high on rst. All registers update on the rising edge of clk only.
- Opcode map, applied bitwise:
  - 0 AND: a&b
  - 1 OR: a|b
  - 2 NOT_A: ~a (b ignored)
  - 3 NAND: ~(a&b)
  - 4 NOR: ~(a|b)
  - 5 XOR: a^b
  - 6 XNOR: ~(a^b)
  - 7 PASS_B: b
  - All eight codes are legal; there is no error path.
- Results are always exactly WIDTH bits. Inversion applies to all WIDTH bits.
- Handshake:
  - Input accept when in_valid && in_ready.
  - Output transfer when out_valid && out_ready.
  - in_ready = !out_valid || out_ready (combinational from out_ready). This allows full throughput of one transaction per cycle under continuous out_ready.
- On input accept: out_y, out_zero, out_parity and out_op load from the current inputs, and out_valid is set to 1.
  - Latency: result is visible the cycle after accept.
- Output transfer without a simultaneous accept: out_valid clears to 0. The data registers hold their last value and are don't-care while out_valid is 0.
- Simultaneous transfer and accept in the same cycle: out_valid stays 1 and the registers take the new result. No bubble and no loss.
- Backpressure (out_valid=1, out_ready=0):
  - in_ready=0.
  - out_y, out_zero, out_parity and out_op stay stable.
  - Input changes are ignored.
- in_valid=0: no state change except through the output transfer rule.
- Flags are computed from the new result, not the previous one:
  - out_zero = (result == 0).
  - out_parity = ^result.
- txn_count:
  - Increments by 1 on each output transfer.
  - Saturates at 2^CNT_W-1 and does not wrap.
- Reset values: out_valid=0, out_y=0, out_zero=1, out_parity=0, out_op=0, txn_count=0. in_ready is 1 in the cycle after reset.
- Reset mid-operation: a held result is discarded, not delivered, and not counted. Reset has priority over accept and transfer in the same cycle.
- Inputs sampled while in_ready=0 have no effect, even if in_valid=1.

Test Plan:
- Opcode sweep, WIDTH=8, a=0xCA, b=0x5C, out_ready=1, ops 0..7 back-to-back -> one result per cycle, each 1 cycle after accept:
  - op0 0x48, op1 0xDE, op2 0x35, op3 0xB7
  - op4 0x21, op5 0x96, op6 0x69, op7 0x5C
  - parity of each: 0,0,0,0,0,0,0,0
  - out_zero never set
  - txn_count=8 at the end
- Zero flag: op0 with a=0xF0, b=0x0F -> out_y=0x00, out_zero=1, out_parity=0. Then op6 with a=b=0x00 -> out_y=0xFF, out_zero=0, out_parity=0.
- Backpressure:
  - Hold out_ready=0 after one accept of (a=0x01, b=0x00, op=1) -> in_ready=0, and out_y stays 0x01 for 5 cycles while in_a/in_op toggle.
  - Raise out_ready together with in_valid for (op=2, a=0x00) -> same-cycle transfer and accept; out_y=0xFF next cycle with out_valid still 1.
- Counter saturation: CNT_W=3, 10 transfers -> txn_count reads 1..7 and then stays at 7.
- Reset mid-operation: accept a transaction, stall with out_ready=0, assert rst for 1 cycle -> next cycle:
  - out_valid=0, out_y=0, out_zero=1, txn_count=0, in_ready=1
  - the stalled result is never delivered.
- Width generality: WIDTH=1, exhaustive a,b in {0,1} for all 8 ops -> each result matches the corresponding single-bit gate truth table; out_parity equals out_y.
